dmg_lcd_capture: RTL and testbench
==================================

Name: dmg_lcd_capture

Overview:
- Upstream stage of the LCD output controller.
- Samples the DMG CPU's raw LCD bus (pixel clock, hsync, vsync, two data bits) into the clk_8m domain and reconstructs pixel x/y positions.
- Writes each 2-bit pixel into the external frame buffer. The output controller later reads that buffer through its xpos/ypos lookup.
- Also reports frame completion and sync errors.

Parameters:
- WIDTH, 160, visible pixels per line
- HEIGHT, 144, visible lines per frame
- ADDR_W, 15, frame buffer address width; must hold WIDTH*HEIGHT-1
- SYNC_STAGES, 2, synchroniser depth on every lcd_* input; minimum 2

Ports:
- clk_8m  in  1  block clock
- rst_n  in  1  reset, asynchronous, active-low
- lcd_cp  in  1  DMG pixel clock
- lcd_hsync  in  1  DMG line sync
- lcd_vsync  in  1  DMG frame sync
- lcd_d0  in  1  DMG pixel data bit 0
- lcd_d1  in  1  DMG pixel data bit 1
- err_clr  in  1  clears sync_err
- wr_en  out  1  frame buffer write strobe
- wr_addr  out  ADDR_W  frame buffer address
- wr_data  out  2  pixel value {d1,d0}
- wr_bank  out  1  bank being written
- rd_bank  out  1  bank holding the last complete frame
- frame_done  out  1  one-cycle pulse when a full frame has been written
- frame_valid  out  1  high once at least one complete frame exists
- sync_err  out  1  sticky error flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0; synchroniser flops 0.
  - State WAIT_VSYNC; x=0, y=0, line_base=0.
- Input synchronisation:
  - All five lcd_* inputs pass through SYNC_STAGES flops, so data stays aligned with lcd_cp.
  - Edges are detected on the synchronised copies.
  - Input constraint: each lcd_cp high and low phase lasts at least 2 clk_8m cycles.
- Pixel sampling: {d1,d0} is taken on the synchronised lcd_cp falling edge. Data is stored raw, with no inversion.
- State machine:
  - WAIT_VSYNC: on lcd_vsync rise, set y=0, line_base=0 and go to LINE_WAIT.
  - LINE_WAIT:
    - lcd_cp edges are ignored here, including the single clock pulse inside hsync.
    - On lcd_hsync fall, set x=0 and go to PIXELS.
  - PIXELS:
    - Each lcd_cp fall writes one pixel and increments x.
    - After pixel x=WIDTH-1: line_base += WIDTH, y++.
    - If y is now HEIGHT, go to FRAME_END; otherwise go to LINE_WAIT.
  - FRAME_END:
    - frame_done pulses high for exactly 1 cycle and frame_valid is set.
    - With the optional feature, banks swap here.
    - Then go to WAIT_VSYNC.
- Write timing:
  - wr_en is high for exactly 1 cycle, one cycle after the detected cp fall.
  - wr_addr = line_base + x; it is an incremental adder, not a multiplier.
  - wr_data holds the sampled pixel.
- Boundary and error conditions:
  - lcd_vsync rise in any state other than WAIT_VSYNC aborts the frame: set sync_err, then restart as for WAIT_VSYNC (y=0, LINE_WAIT). No frame_done is issued.
  - lcd_hsync rise in PIXELS with x<WIDTH (short line): set sync_err and discard the rest of the line. Advance line_base and y as for a complete line, then enter LINE_WAIT; this path also honours the y==HEIGHT check.
  - lcd_cp falls arriving while hsync is high are not written.
  - Simultaneous lcd_vsync rise and lcd_hsync fall in the same cycle: vsync is processed first and the hsync fall is lost. The frame then starts at the next hsync fall.
  - err_clr clears sync_err. If err_clr and a new error occur in the same cycle, the error wins.
- Mid-frame reset: everything returns to reset values. Frame buffer contents are not touched; frame_valid=0 until the next complete frame.

Optional Feature:
- Macro: DMG_CAPTURE_DOUBLE_BUF_EN
- Defined:
  - wr_bank toggles in FRAME_END and rd_bank always equals ~wr_bank.
  - The output side reads rd_bank, so a partially written frame is never displayed.
  - An aborted frame does not toggle the bank.
- Undefined: wr_bank=0 and rd_bank=0 permanently, i.e. a single buffer with possible tearing.

Test Plan:
- Reset, then one clean frame (vsync rise, 144 lines each of 160 pixels, with an extra cp pulse inside hsync) -> 23040 wr_en pulses with wr_addr 0..23039 in order; frame_done pulses once after addr 23039; frame_valid=1; sync_err=0.
- Pixel value check: line 5 pixel 7 driven d1=1,d0=0 -> write at wr_addr 807 with wr_data=2'b10.
- Short line: line 3 ends after 100 pixels (hsync rises early) -> sync_err=1. Line 4 pixel 0 is written to addr 640; no writes to addrs 580..639.
- Vsync during line 50 -> sync_err=1, no frame_done; next write goes to addr 0 after the following hsync fall. Asserting err_clr then clears sync_err to 0.
- rst_n low during line 70, released, followed by a full frame -> all outputs 0 during reset; frame_valid is 0 until that frame's frame_done.
- With DMG_CAPTURE_DOUBLE_BUF_EN defined, two complete frames -> wr_bank sequence 0→1→0 and rd_bank=~wr_bank. With the macro undefined -> both stay 0.

Source files
------------

// File: rtl/dmg_lcd_capture.sv
// DMG LCD bus capture: synchronises the raw Game Boy LCD bus into clk_8m,
// rebuilds pixel x/y and writes each 2-bit pixel to the frame buffer.
// Optional feature: define DMG_CAPTURE_DOUBLE_BUF_EN for ping-pong banks.
module dmg_lcd_capture #(
  parameter int unsigned WIDTH       = 160,
  parameter int unsigned HEIGHT      = 144,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_8m,
  input  logic              rst_n,
  input  logic              lcd_cp,
  input  logic              lcd_hsync,
  input  logic              lcd_vsync,
  input  logic              lcd_d0,
  input  logic              lcd_d1,
  input  logic              err_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_data,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              frame_done,
  output logic              frame_valid,
  output logic              sync_err
);

  // Fewer than two stages is not a synchroniser; clamp rather than fail.
  localparam int unsigned NSync = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned XW    = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW    = $clog2(HEIGHT + 1);

  // Bit positions inside the packed bus vector.
  localparam int unsigned IdxCp = 0;
  localparam int unsigned IdxHs = 1;
  localparam int unsigned IdxVs = 2;
  localparam int unsigned IdxD0 = 3;
  localparam int unsigned IdxD1 = 4;

  typedef enum logic [1:0] {
    StWaitVsync,
    StLineWait,
    StPixels,
    StFrameEnd
  } state_e;

  logic [4:0]        sync_d [NSync];
  logic [4:0]        sync_q [NSync];
  logic [4:0]        prev_d, prev_q;
  logic [4:0]        bus;

  state_e            state_d, state_q;
  logic [XW-1:0]     x_d, x_q;
  logic [YW-1:0]     y_d, y_q;
  logic [ADDR_W-1:0] line_base_d, line_base_q;
  logic              wr_en_d, wr_en_q;
  logic [ADDR_W-1:0] wr_addr_d, wr_addr_q;
  logic [1:0]        wr_data_d, wr_data_q;
  logic              frame_done_d, frame_done_q;
  logic              frame_valid_d, frame_valid_q;
  logic              sync_err_d, sync_err_q;
  logic              wr_bank_d, wr_bank_q;
  logic              rd_bank_d, rd_bank_q;

  logic              cp_fall, hs_rise, hs_fall, vs_rise, hs_lvl;
  logic              err_set, line_end;

  // Synchroniser shift chain; all five lines travel together so data stays aligned with cp.
  always_comb begin
    sync_d[0] = {lcd_d1, lcd_d0, lcd_vsync, lcd_hsync, lcd_cp};
    for (int i = 1; i < int'(NSync); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    bus    = sync_q[NSync-1];
    prev_d = bus;
  end

  // Synchroniser and edge-history registers.
  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NSync); i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      for (int i = 0; i < int'(NSync); i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q <= prev_d;
    end
  end

  // Edge detection on the synchronised copies.
  always_comb begin
    cp_fall = prev_q[IdxCp] & ~bus[IdxCp];
    hs_rise = ~prev_q[IdxHs] & bus[IdxHs];
    hs_fall = prev_q[IdxHs] & ~bus[IdxHs];
    vs_rise = ~prev_q[IdxVs] & bus[IdxVs];
    hs_lvl  = bus[IdxHs];
  end

  // Capture FSM: next state, position counters and write strobe.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    line_base_d   = line_base_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_done_d  = 1'b0;
    frame_valid_d = frame_valid_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    err_set       = 1'b0;
    line_end      = 1'b0;

    unique case (state_q)
      StWaitVsync: begin
        if (vs_rise) begin
          y_d         = '0;
          line_base_d = '0;
          state_d     = StLineWait;
        end
      end
      StLineWait: begin
        if (vs_rise) begin
          err_set = 1'b1;
        end else if (hs_fall) begin
          x_d     = '0;
          state_d = StPixels;
        end
      end
      StPixels: begin
        if (vs_rise) begin
          err_set = 1'b1;
        end else if (hs_rise) begin
          // Short line: drop the remainder but keep the line grid intact.
          err_set  = 1'b1;
          line_end = 1'b1;
        end else if (cp_fall && !hs_lvl) begin
          wr_en_d   = 1'b1;
          wr_addr_d = line_base_q + ADDR_W'(x_q);
          wr_data_d = {bus[IdxD1], bus[IdxD0]};
          if (x_q == XW'(WIDTH - 1)) begin
            line_end = 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      StFrameEnd: begin
        if (vs_rise) begin
          err_set = 1'b1;
        end else begin
          frame_done_d  = 1'b1;
          frame_valid_d = 1'b1;
`ifdef DMG_CAPTURE_DOUBLE_BUF_EN
          // rd_bank takes the bank just finished, i.e. ~wr_bank from here on.
          wr_bank_d = ~wr_bank_q;
          rd_bank_d = wr_bank_q;
`else
          wr_bank_d = 1'b0;
          rd_bank_d = 1'b0;
`endif
          state_d = StWaitVsync;
        end
      end
      default: state_d = StWaitVsync;
    endcase

    if (line_end) begin
      line_base_d = line_base_q + ADDR_W'(WIDTH);
      y_d         = y_q + 1'b1;
      state_d     = (y_q + 1'b1 == YW'(HEIGHT)) ? StFrameEnd : StLineWait;
    end

    // A vsync rise outside WAIT_VSYNC aborts the frame and restarts it.
    if (vs_rise && state_q != StWaitVsync) begin
      y_d         = '0;
      line_base_d = '0;
      state_d     = StLineWait;
    end
  end

  // Sticky error: a new error beats a simultaneous clear.
  always_comb begin
    sync_err_d = (sync_err_q & ~err_clr) | err_set;
  end

  // State and output registers.
  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StWaitVsync;
      x_q           <= '0;
      y_q           <= '0;
      line_base_q   <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_base_q   <= line_base_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_done  = frame_done_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign wr_bank     = wr_bank_q;
  assign rd_bank     = rd_bank_q;

endmodule

// File: tb/tb_dmg_lcd_capture.sv
// Scoreboard bench for dmg_lcd_capture on a reduced 20x12 frame.
module tb_dmg_lcd_capture;

  localparam int unsigned W  = 20;
  localparam int unsigned H  = 12;
  localparam int unsigned AW = 8;
  localparam int          P  = 3;  // clk_8m cycles per lcd_cp phase

`ifdef DMG_CAPTURE_DOUBLE_BUF_EN
  localparam bit Db = 1'b1;
`else
  localparam bit Db = 1'b0;
`endif

  logic          clk_8m = 1'b0;
  logic          rst_n = 1'b0;
  logic          lcd_cp = 1'b0, lcd_hsync = 1'b0, lcd_vsync = 1'b0;
  logic          lcd_d0 = 1'b0, lcd_d1 = 1'b0, err_clr = 1'b0;
  logic          wr_en, wr_bank, rd_bank, frame_done, frame_valid, sync_err;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_data;

  int errors = 0;
  int checks = 0;
  int exp_done = 0;
  logic [AW+1:0] exp_q[$];
  logic [AW+1:0] mon_e;

  dmg_lcd_capture #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .SYNC_STAGES(2)
  ) dut (
    .clk_8m(clk_8m), .rst_n(rst_n), .lcd_cp(lcd_cp), .lcd_hsync(lcd_hsync),
    .lcd_vsync(lcd_vsync), .lcd_d0(lcd_d0), .lcd_d1(lcd_d1), .err_clr(err_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bank(wr_bank),
    .rd_bank(rd_bank), .frame_done(frame_done), .frame_valid(frame_valid),
    .sync_err(sync_err)
  );

  always #5 clk_8m = ~clk_8m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every write and checks frame_done.
  always @(negedge clk_8m) begin
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected none", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_e[AW+1:2]));
        check("wr_data", 32'(wr_data), 32'(mon_e[1:0]));
      end
    end
    if (rst_n && frame_done) begin
      check("frame_done_expected", 32'(exp_done > 0), 32'd1);
      if (exp_done > 0) exp_done--;
      check("queue_empty_at_done", exp_q.size(), 0);
      check("frame_valid_at_done", 32'(frame_valid), 32'd1);
    end
  end

  function automatic logic [1:0] pix(input int y, input int x);
    int t;
    if (y == 5 && x == 7) return 2'b10;
    t = (x + y + 1) % 4;
    return t[1:0];
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_8m);
  endtask

  task automatic cp_pulse(input logic [1:0] d, input bit wr, input int addr);
    lcd_d1 = d[1];
    lcd_d0 = d[0];
    lcd_cp = 1'b1;
    wait_clk(P);
    lcd_cp = 1'b0;
    if (wr) exp_q.push_back({addr[AW-1:0], d});
    wait_clk(P);
  endtask

  // One line: hsync with a stray cp pulse inside it, then npix pixels.
  task automatic do_line(input int y, input int npix);
    lcd_hsync = 1'b1;
    wait_clk(P);
    cp_pulse(2'b11, 1'b0, 0);
    lcd_hsync = 1'b0;
    wait_clk(P);
    for (int x = 0; x < npix; x++) cp_pulse(pix(y, x), 1'b1, y * int'(W) + x);
  endtask

  task automatic vsync_pulse();
    lcd_vsync = 1'b1;
    wait_clk(4);
    lcd_vsync = 1'b0;
    wait_clk(2);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) wait_clk(1);
    check("writes_drained", exp_q.size(), 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && exp_done > 0; i++) wait_clk(1);
    check("frame_done_seen", exp_done, 0);
  endtask

  task automatic check_reset_outputs();
    check("reset_outputs",
          32'({wr_en, wr_addr, wr_data, wr_bank, rd_bank, frame_done, frame_valid, sync_err}),
          32'd0);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    wait_clk(1);
  endtask

  initial begin
    wait_clk(3);
    check_reset_outputs();
    rst_n = 1'b1;
    wait_clk(3);

    // Frame A: clean, includes the line 5 pixel 7 value check (addr 107, 2'b10).
    vsync_pulse();
    for (int y = 0; y < int'(H); y++) begin
      if (y == int'(H) - 1) exp_done = 1;
      do_line(y, W);
    end
    wait_done();
    drain();
    check("a_frame_valid", 32'(frame_valid), 32'd1);
    check("a_sync_err", 32'(sync_err), 32'd0);
    check("a_wr_bank", 32'(wr_bank), 32'(Db));
    check("a_rd_bank", 32'(rd_bank), 32'd0);

    // Frame B: line 3 has only 12 pixels; line 4 starts at addr 80.
    vsync_pulse();
    check("b_sync_err_before", 32'(sync_err), 32'd0);
    for (int y = 0; y < int'(H); y++) begin
      if (y == int'(H) - 1) exp_done = 1;
      do_line(y, (y == 3) ? 12 : int'(W));
      if (y == 4) check("b_short_line_err", 32'(sync_err), 32'd1);
    end
    wait_done();
    drain();
    check("b_wr_bank", 32'(wr_bank), 32'd0);
    check("b_rd_bank", 32'(rd_bank), 32'(Db));
    pulse_err_clr();
    check("b_err_clr", 32'(sync_err), 32'd0);

    // Frame C: vsync during line 6 aborts; next line restarts at addr 0.
    vsync_pulse();
    for (int y = 0; y < 6; y++) do_line(y, W);
    do_line(6, 5);
    wait_clk(P);
    vsync_pulse();
    drain();
    check("c_abort_err", 32'(sync_err), 32'd1);
    do_line(0, W);
    do_line(1, W);
    drain();
    check("c_bank_kept", 32'({wr_bank, rd_bank}), 32'({1'b0, Db}));
    pulse_err_clr();
    check("c_err_clr", 32'(sync_err), 32'd0);

    // Reset during line 8 of the restarted frame.
    for (int y = 2; y < 8; y++) do_line(y, W);
    do_line(8, 4);
    drain();
    rst_n = 1'b0;
    wait_clk(2);
    check_reset_outputs();
    rst_n = 1'b1;
    wait_clk(3);

    // Frame D: frame_valid stays 0 until its frame_done.
    vsync_pulse();
    for (int y = 0; y < int'(H); y++) begin
      if (y == int'(H) - 1) begin
        check("d_valid_before_done", 32'(frame_valid), 32'd0);
        exp_done = 1;
      end
      do_line(y, W);
    end
    wait_done();
    drain();
    check("d_frame_valid", 32'(frame_valid), 32'd1);
    check("d_sync_err", 32'(sync_err), 32'd0);
    check("d_wr_bank", 32'(wr_bank), 32'(Db));
    check("d_rd_bank", 32'(rd_bank), 32'd0);

    wait_clk(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish within 1ms");
    $fatal(1);
  end

endmodule
